// File: rtl/meter_pkg.sv
// -----------------------------------------------------------------------------
// meter_pkg
// Shared definitions for the clock period meter and other slow-signal readers.
//   meter_state_e   : measurement FSM state encoding (IDLE, ARM, MEAS)
//   DEF_CNT_W       : default counter / result width
//   DEF_TIMEOUT_CYC : default cycles without a rising edge before timeout
//   DEF_SYNC_STAGES : default synchronizer depth
// -----------------------------------------------------------------------------
package meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } meter_state_e;

  localparam int unsigned DEF_CNT_W       = 32;
  localparam int unsigned DEF_TIMEOUT_CYC = 1000;
  localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sig_sync_edge.sv
// -----------------------------------------------------------------------------
// sig_sync_edge
// Multi-flop synchronizer for a slow asynchronous input plus a one-cycle
// rising-edge pulse. Reusable by any slow-signal reader.
// Ports:
//   clkin  : clock, all logic on posedge
//   rst_n  : synchronous active-low reset, clears all flops to 0
//   sig_in : asynchronous input
//   s      : synchronized level (SYNC_STAGES flops deep)
//   rise   : s & ~prev, one cycle per synchronized rising edge
// -----------------------------------------------------------------------------
module sig_sync_edge #(
  parameter int unsigned SYNC_STAGES = meter_pkg::DEF_SYNC_STAGES
) (
  input  logic clkin,
  input  logic rst_n,
  input  logic sig_in,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  // prev resets to 0, so an input already high at reset release yields one
  // rise; the meter treats it as an arming edge only.
  assign rise = s & ~prev_q;

endmodule

// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
// Measures the period of a slow asynchronous square wave in clkin cycles.
// The first synchronized rising edge arms the meter; every later rising edge
// reports the cycles since the previous one. A sticky timeout flags a missing
// edge for TIMEOUT_CYC cycles and forces a re-arm.
//
// Optional feature (macro CLK_PERIOD_METER_DUTY_MEAS_EN): high_time reports
// the cycles the synchronized input was high within the last period. Without
// the macro high_time is tied to 0.
//
// Ports:
//   clkin      : system clock, posedge
//   rst_n      : synchronous active-low reset
//   enable     : measurement enable; low forces IDLE
//   sig_in     : asynchronous signal under measurement
//   period     : cycles between the last two accepted rising edges
//   high_time  : high cycles within the last period (optional feature)
//   meas_valid : one-cycle pulse when period/high_time update
//   timeout    : sticky no-edge flag
//   dbg_state  : current FSM state
//
// Handshake: meas_valid is a pure strobe with no ready; period and high_time
// are valid in the cycle meas_valid is high and hold until the next strobe.
// -----------------------------------------------------------------------------
module clk_period_meter
  import meter_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout,
  output meter_state_e     dbg_state
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic s_sync;
  logic rise;

  sig_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clkin  (clkin),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .s      (s_sync),
    .rise   (rise)
  );

  meter_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             meas_valid_q, meas_valid_d;
  logic             timeout_q, timeout_d;
  logic             tmo_hit;

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      period_q     <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign tmo_hit = (cnt_q == TIMEOUT_LAST);

  // Priority inside ARM/MEAS: enable low, then rise, then timeout. A rise on
  // the threshold cycle therefore still produces a measurement.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    meas_valid_d = 1'b0;
    timeout_d    = timeout_q;
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        timeout_d = 1'b0;
        if (enable) state_d = ARM;
      end
      ARM, MEAS: begin
        if (!enable) begin
          state_d   = IDLE;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end else if (rise) begin
          cnt_d   = '0;
          state_d = MEAS;
          if (state_q == MEAS) begin
            // cnt_q is one less than the elapsed cycles since the last rise.
            period_d     = cnt_q + CNT_ONE;
            meas_valid_d = 1'b1;
            timeout_d    = 1'b0;
          end
        end else if (tmo_hit) begin
          // The edge history is lost; the next period needs two new rises.
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = ARM;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef CLK_PERIOD_METER_DUTY_MEAS_EN
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             stay_meas;

  // Counting continues only while the FSM remains in MEAS without a
  // measurement; every other path restarts the high counter at 0.
  assign stay_meas = (state_q == MEAS) && (state_d == MEAS) && !meas_valid_d;

  always_comb begin
    hcnt_d = '0;
    high_d = high_q;
    if (meas_valid_d) begin
      // The rise cycle itself has s=1 and belongs to the finished period.
      high_d = hcnt_q + CNT_W'(s_sync);
    end else if (stay_meas) begin
      hcnt_d = hcnt_q + CNT_W'(s_sync);
    end
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      high_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      high_q <= high_d;
    end
  end

  assign high_time = high_q;
`else
  logic unused_s_sync;
  assign unused_s_sync = s_sync;
  assign high_time     = '0;
`endif

  assign period     = period_q;
  assign meas_valid = meas_valid_q;
  assign timeout    = timeout_q;
  assign dbg_state  = state_q;

endmodule
